gaussian_conv: RTL and testbench
================================

// Module: gaussian_conv
// PURPOSE
//  Consumes the kernel window produced by conv_memory and computes one Gaussian-filtered output pixel per window.
//  Drives conv_memory's new_trans/new_sample_req handshake; new_sample_req also steps pixel_pos.
//  Weights: binomial C(k-1,i)*C(k-1,j), built internally; one MAC per clock, k^2 cycles per pixel.
//  Output: registered stream with valid/ready and the pixel coordinates, for the downstream scaler/FAST stage.
// PARAMETERS
//  MAX_KERNEL   9   largest supported kernel side (odd)
//  PIXEL_DEPTH  8   bits per pixel
//  X_MAX        16  max image width
//  Y_MAX        16  max image height
// PORTS
//  clk               in   1      single clock, rising edge
//  rst               in   1      asynchronous, active-high reset
//  start             in   1      1-cycle pulse: begin a frame
//  kernel_size       in   8      odd kernel side, 1..MAX_KERNEL; sampled on start
//  new_trans         out  1      1-cycle pulse to conv_memory/pixel_pos: restart scan
//  new_sample_ready  in   1      working_memory holds a valid window (level)
//  working_memory    in   MAX_KERNEL*MAX_KERNEL*PIXEL_DEPTH   window, [row][col][bits]
//  curr_x            in   $clog2(X_MAX)   window centre x from pixel_pos
//  curr_y            in   $clog2(Y_MAX)   window centre y from pixel_pos
//  end_pos           in   1      pixel_pos at final pixel
//  new_sample_req    out  1      1-cycle pulse: fetch next window / advance position
//  out_valid         out  1      out_pix/out_x/out_y valid
//  out_ready         in   1      downstream accepts when out_valid&&out_ready
//  out_pix           out  PIXEL_DEPTH   filtered pixel
//  out_x, out_y      out  as curr_x/curr_y   coordinates of out_pix
//  busy              out  1      FSM not IDLE/DONE
//  done              out  1      1-cycle pulse after final pixel accepted
//  err_ksize         out  1      sticky until next start: kernel_size invalid
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, accumulator/counters 0. A reset in any state aborts the frame with no output.
//  FSM: IDLE -> INIT -> WAIT -> MAC -> NORM -> OUT -> {REQ -> GAP -> WAIT | DONE -> IDLE}.
//  IDLE: on start, latch k=kernel_size. If k even, 0 or >MAX_KERNEL: set err_ksize and stay IDLE. Otherwise clear err_ksize and go INIT.
//  INIT: new_trans=1 for exactly one cycle; go WAIT.
//  WAIT: on new_sample_ready=1, latch curr_x/curr_y/end_pos, clear acc, set (i,j)=(0,0); go MAC.
//  MAC: each cycle acc += w(i,j)*working_memory[i][j]. j increments and wraps at k-1, then i increments.
//    Exactly k^2 cycles; then NORM. working_memory is stable until new_sample_req (conv_memory contract).
//  Widths: w <= C(8,4)^2=4900 (13b); acc = PIXEL_DEPTH+2*(MAX_KERNEL-1) bits (24b), unsigned, no overflow.
//  NORM: s=2*(k-1); res=(acc + (s?1<<(s-1):0)) >> s, clamped to 2^PIXEL_DEPTH-1. k=1 -> res=pixel exactly.
//  OUT: hold until output register empty (out_valid=0, or accepted this cycle).
//    Then load out_pix/out_x/out_y and set out_valid. Last pixel -> DONE; else REQ.
//  REQ: new_sample_req=1 for one cycle; GAP: one idle cycle so conv_memory can drop ready; go WAIT.
//  Latency: out_valid rises k^2+2 cycles after new_sample_ready is sampled high (register empty).
//  Backpressure: a full output register stalls in OUT; no new_sample_req is issued while stalled.
//  out_valid/out_* are held stable until accepted.
//  DONE: wait for final out_valid acceptance, pulse done 1 cycle, go IDLE.
//  start is ignored while busy. new_sample_ready outside WAIT is ignored.
//  Pixels emit in pixel_pos serpentine order; count = max_x*max_y per frame.
// TESTING
//  k=1, 5x5 test image, out_ready=1 -> 25 outputs, out_pix==source pixel at (out_x,out_y), then done pulse.
//  k=3, window all 100 -> out_pix=100; window all 255 -> 255 (no overflow); all 0 -> 0.
//  k=3, centre 255, rest 0 -> 4*255/16=63.75 -> out_pix=64; k=9 centre 255 -> 4900*255/65536 -> 19.
//  out_ready=0 for 40 cycles mid-frame -> out_* frozen, zero new_sample_req pulses, resumes with no loss/dup.
//  start with kernel_size=4, then 11 -> err_ksize=1, no new_trans, busy=0; next start with 3 clears it.
//  rst asserted mid-MAC -> outputs 0 immediately, IDLE; a fresh start on 9x9 k=3 completes with 81 outputs.

Source files
------------

// File: rtl/gaussian_conv_if.sv
// gaussian_conv_if: filtered-pixel output stream (valid/ready with pixel coordinates)
interface gaussian_conv_if #(
    parameter int PIXEL_DEPTH = 8,
    parameter int XW          = 4,
    parameter int YW          = 4
);
    logic                   out_valid;
    logic                   out_ready;
    logic [PIXEL_DEPTH-1:0] out_pix;
    logic [XW-1:0]          out_x;
    logic [YW-1:0]          out_y;

    modport master (output out_valid, out_pix, out_x, out_y, input out_ready);
    modport slave  (input out_valid, out_pix, out_x, out_y, output out_ready);
endinterface

// File: rtl/gaussian_conv.sv
// gaussian_conv: binomial-weighted window MAC producing one Gaussian-filtered pixel per window
module gaussian_conv #(
    parameter int MAX_KERNEL  = 9,
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX       = 16,
    parameter int Y_MAX       = 16,
    localparam int XW = $clog2(X_MAX),
    localparam int YW = $clog2(Y_MAX)
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [7:0]                                            kernel_size,
    output logic                                                  new_trans,
    input  logic                                                  new_sample_ready,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIXEL_DEPTH-1:0] working_memory,
    input  logic [XW-1:0]                                         curr_x,
    input  logic [YW-1:0]                                         curr_y,
    input  logic                                                  end_pos,
    output logic                                                  new_sample_req,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  err_ksize,
    gaussian_conv_if.master                                       out_if
);
    localparam int KW   = $clog2(MAX_KERNEL + 1);
    localparam int IW   = $clog2(MAX_KERNEL);
    localparam int CW   = MAX_KERNEL;
    localparam int ACCW = PIXEL_DEPTH + 2 * (MAX_KERNEL - 1);
    localparam int SW   = $clog2(2 * MAX_KERNEL);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] INIT = 4'd1;
    localparam logic [3:0] WAIT = 4'd2;
    localparam logic [3:0] MAC  = 4'd3;
    localparam logic [3:0] NORM = 4'd4;
    localparam logic [3:0] OUT  = 4'd5;
    localparam logic [3:0] REQ  = 4'd6;
    localparam logic [3:0] GAP  = 4'd7;
    localparam logic [3:0] DONE = 4'd8;

    // Pascal's triangle, entry (n,r) at slot n*MAX_KERNEL+r; the 2-D weight is the product of two row entries
    function automatic logic [MAX_KERNEL*MAX_KERNEL*CW-1:0] pascal_tbl();
        logic [MAX_KERNEL*MAX_KERNEL*CW-1:0] p;
        p = '0;
        for (int n = 0; n < MAX_KERNEL; n++) begin
            for (int r = 0; r <= n; r++) begin
                if (r == 0 || r == n)
                    p[(n*MAX_KERNEL+r)*CW +: CW] = CW'(1);
                else
                    p[(n*MAX_KERNEL+r)*CW +: CW] = p[((n-1)*MAX_KERNEL+r-1)*CW +: CW]
                                                 + p[((n-1)*MAX_KERNEL+r)*CW +: CW];
            end
        end
        return p;
    endfunction

    localparam logic [MAX_KERNEL*MAX_KERNEL*CW-1:0] PASCAL = pascal_tbl();

    logic [3:0]             state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [IW-1:0]          i_q, i_d, j_q, j_d;
    logic [ACCW-1:0]        acc_q, acc_d;
    logic [PIXEL_DEPTH-1:0] res_q, res_d, pix_q, pix_d;
    logic [XW-1:0]          x_q, x_d, ox_q, ox_d;
    logic [YW-1:0]          y_q, y_d, oy_q, oy_d;
    logic                   last_q, last_d, ov_q, ov_d, done_q, done_d, err_q, err_d;

    logic [KW-1:0]          km1;
    logic [CW-1:0]          coef_i, coef_j;
    logic [PIXEL_DEPTH-1:0] pix_ij;
    logic [SW-1:0]          s;
    logic [ACCW:0]          rnd, shifted;
    logic                   accept, reg_free, ks_ok, j_wrap;

    // Weight lookup, rounding normalisation and output-register handshake
    always_comb begin
        km1      = k_q - KW'(1);
        coef_i   = PASCAL[(int'(km1)*MAX_KERNEL + int'(i_q))*CW +: CW];
        coef_j   = PASCAL[(int'(km1)*MAX_KERNEL + int'(j_q))*CW +: CW];
        pix_ij   = working_memory[i_q][j_q];
        j_wrap   = (j_q == IW'(km1));
        s        = SW'(32'(km1) * 2);
        rnd      = {1'b0, acc_q} + ((s != '0) ? ((ACCW+1)'(1) << (s - SW'(1))) : '0);
        shifted  = rnd >> s;
        accept   = ov_q && out_if.out_ready;
        reg_free = !ov_q || accept;
        ks_ok    = kernel_size[0] && (kernel_size <= 8'(MAX_KERNEL));
    end

    // Frame sequencing FSM and datapath next-state
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        res_d   = res_q;
        x_d     = x_q;
        y_d     = y_q;
        last_d  = last_q;
        ov_d    = ov_q && !accept;
        pix_d   = pix_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                err_d = !ks_ok;
                if (ks_ok) begin
                    k_d     = kernel_size[KW-1:0];
                    state_d = INIT;
                end
            end
            INIT: state_d = WAIT;
            WAIT: if (new_sample_ready) begin
                x_d     = curr_x;
                y_d     = curr_y;
                last_d  = end_pos;
                acc_d   = '0;
                i_d     = '0;
                j_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d   = acc_q + ACCW'(coef_i) * ACCW'(coef_j) * ACCW'(pix_ij);
                j_d     = j_wrap ? '0 : j_q + IW'(1);
                i_d     = j_wrap ? i_q + IW'(1) : i_q;
                state_d = (j_wrap && i_q == IW'(km1)) ? NORM : MAC;
            end
            NORM: begin
                res_d   = (|shifted[ACCW:PIXEL_DEPTH]) ? '1 : shifted[PIXEL_DEPTH-1:0];
                state_d = OUT;
            end
            OUT: if (reg_free) begin
                ov_d    = 1'b1;
                pix_d   = res_q;
                ox_d    = x_q;
                oy_d    = y_q;
                state_d = last_q ? DONE : REQ;
            end
            REQ:  state_d = GAP;
            GAP:  state_d = WAIT;
            DONE: if (reg_free) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
            ov_q    <= 1'b0;
            pix_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
            ov_q    <= ov_d;
            pix_q   <= pix_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign new_trans        = (state_q == INIT);
    assign new_sample_req   = (state_q == REQ);
    assign busy             = (state_q != IDLE) && (state_q != DONE);
    assign done             = done_q;
    assign err_ksize        = err_q;
    assign out_if.out_valid = ov_q;
    assign out_if.out_pix   = pix_q;
    assign out_if.out_x     = ox_q;
    assign out_if.out_y     = oy_q;
endmodule

// File: tb/tb_gaussian_conv.sv
// tb_gaussian_conv: conv_memory/pixel_pos model feeding a scoreboard of expected filtered pixels
module tb_gaussian_conv;
    localparam int MK = 9;
    localparam int PD = 8;
    localparam int XW = 4;
    localparam int YW = 4;

    logic                           clk = 1'b0;
    logic                           rst, start, new_trans, new_sample_ready, endp;
    logic                           new_sample_req, busy, done, err_ksize;
    logic [7:0]                     kernel_size;
    logic [MK-1:0][MK-1:0][PD-1:0]  wm;
    logic [XW-1:0]                  cx;
    logic [YW-1:0]                  cy;

    gaussian_conv_if #(.PIXEL_DEPTH(PD), .XW(XW), .YW(YW)) oif();

    gaussian_conv #(.MAX_KERNEL(MK), .PIXEL_DEPTH(PD), .X_MAX(16), .Y_MAX(16)) dut (
        .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
        .new_trans(new_trans), .new_sample_ready(new_sample_ready),
        .working_memory(wm), .curr_x(cx), .curr_y(cy), .end_pos(endp),
        .new_sample_req(new_sample_req), .busy(busy), .done(done),
        .err_ksize(err_ksize), .out_if(oif)
    );

    always #5 clk = ~clk;

    typedef struct {int pix; int x; int y;} exp_t;
    exp_t sbq[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, rdy_cyc = 0, rise_cyc = 0;
    int nt_cnt = 0, req_cnt = 0, out_cnt = 0, done_cnt = 0, last_pix = 0;
    int cfg_k = 1, cfg_w = 1, cfg_h = 1, cfg_mode = 0, cfg_fill = 0;
    int px = 0, py = 0, dly = 0;
    bit active = 0, stall = 0, pv = 0;
    logic [7:0] img [16][16];

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check, reports mismatches
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int binom(input int n, input int r);
        int c = 1;
        for (int t = 0; t < r; t++) c = c * (n - t) / (t + 1);
        return c;
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Build the window for (px,py), drive it and push the reference result
    task automatic present();
        int r, v, acc, s, res;
        exp_t e;
        r   = (cfg_k - 1) / 2;
        acc = 0;
        for (int i = 0; i < MK; i++) begin
            for (int j = 0; j < MK; j++) begin
                if (i < cfg_k && j < cfg_k) begin
                    if (cfg_mode == 0)
                        v = img[clampi(py + i - r, cfg_h - 1)][clampi(px + j - r, cfg_w - 1)];
                    else if (cfg_mode == 1)
                        v = cfg_fill;
                    else
                        v = (i == r && j == r) ? cfg_fill : 0;
                    wm[i][j] = 8'(v);
                    acc += binom(cfg_k - 1, i) * binom(cfg_k - 1, j) * v;
                end else begin
                    wm[i][j] = 8'hA5;
                end
            end
        end
        s   = 2 * (cfg_k - 1);
        res = (acc + ((s > 0) ? (1 << (s - 1)) : 0)) >> s;
        if (res > 255) res = 255;
        e.pix = res;
        e.x   = px;
        e.y   = py;
        sbq.push_back(e);
        cx    = XW'(px);
        cy    = YW'(py);
        endp  = (py == cfg_h - 1) && ((py % 2 == 0) ? (px == cfg_w - 1) : (px == 0));
        new_sample_ready = 1'b1;
        rdy_cyc = cyc;
    endtask

    // conv_memory + pixel_pos model: serpentine scan, ready drops on each request
    initial begin
        new_sample_ready = 1'b0;
        wm   = '0;
        cx   = '0;
        cy   = '0;
        endp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                new_sample_ready = 1'b0;
                active = 0;
                dly = 0;
            end else begin
                if (new_trans) begin
                    nt_cnt++;
                    px = 0;
                    py = 0;
                    active = 1;
                    new_sample_ready = 1'b0;
                    dly = 2;
                end
                if (new_sample_req) begin
                    req_cnt++;
                    new_sample_ready = 1'b0;
                    dly = 2;
                    if (py % 2 == 0) begin
                        if (px == cfg_w - 1) py++; else px++;
                    end else begin
                        if (px == 0) py++; else px--;
                    end
                end
                if (active && !new_sample_ready && dly > 0) begin
                    dly--;
                    if (dly == 0) present();
                end
            end
        end
    end

    // Output sink: drives out_ready, pops and compares accepted pixels
    initial begin
        exp_t e;
        oif.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            oif.out_ready = !stall;
            if (oif.out_valid && !pv) rise_cyc = cyc;
            pv = oif.out_valid;
            if (done) done_cnt++;
            if (oif.out_valid && oif.out_ready) begin
                out_cnt++;
                last_pix = oif.out_pix;
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("pix", oif.out_pix, e.pix);
                    chk("x", oif.out_x, e.x);
                    chk("y", oif.out_y, e.y);
                    if (cfg_k == 1 && cfg_mode == 0)
                        chk("k1_src", oif.out_pix, img[oif.out_y][oif.out_x]);
                end
            end
        end
    end

    task automatic start_frame(input int k, input int w, input int h, input int mode, input int fill);
        cfg_k = k;
        cfg_w = w;
        cfg_h = h;
        cfg_mode = mode;
        cfg_fill = fill;
        @(negedge clk);
        kernel_size = 8'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int d0, input int n);
        int t = 0;
        while (done_cnt == d0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("done_pulse", done_cnt - d0, 1);
        chk("out_count", out_cnt - base, n);
        chk("sb_left", sbq.size(), 0);
        chk("busy_after", busy, 0);
    endtask

    task automatic run_frame(input int k, input int w, input int h, input int mode, input int fill);
        int base = out_cnt, d0 = done_cnt;
        start_frame(k, w, h, mode, fill);
        wait_done(base, d0, w * h);
    endtask

    initial begin
        int base, d0, nt0, r0, t;
        rst = 1'b1;
        start = 1'b0;
        kernel_size = '0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = 8'($urandom_range(0, 255));
        img[2][3] = 8'd255;
        repeat (3) @(negedge clk);
        chk("rst_valid", oif.out_valid, 0);
        chk("rst_pix", oif.out_pix, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trans", new_trans, 0);
        chk("rst_req", new_sample_req, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_ksize, 0);
        rst = 1'b0;

        run_frame(1, 5, 5, 0, 0);
        run_frame(3, 1, 1, 1, 100);
        chk("lat_k3", rise_cyc - rdy_cyc - 1, 11);
        run_frame(3, 1, 1, 1, 255);
        run_frame(3, 1, 1, 1, 0);
        run_frame(3, 1, 1, 2, 255);
        chk("k3_impulse", last_pix, 64);
        run_frame(9, 1, 1, 2, 255);
        chk("k9_impulse", last_pix, 19);
        chk("lat_k9", rise_cyc - rdy_cyc - 1, 83);
        run_frame(5, 4, 4, 0, 0);

        // backpressure: hold output for 40 cycles mid-frame
        base = out_cnt;
        d0 = done_cnt;
        start_frame(3, 6, 6, 0, 0);
        t = 0;
        while (out_cnt - base < 10 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        stall = 1;
        repeat (20) @(negedge clk);
        r0 = req_cnt;
        repeat (40) @(negedge clk);
        chk("stall_valid", oif.out_valid, 1);
        chk("stall_req", req_cnt - r0, 0);
        if (sbq.size() > 0) begin
            chk("stall_pix", oif.out_pix, sbq[0].pix);
            chk("stall_x", oif.out_x, sbq[0].x);
            chk("stall_y", oif.out_y, sbq[0].y);
        end else begin
            chk("stall_sb", sbq.size(), 1);
        end
        stall = 0;
        wait_done(base, d0, 36);

        // invalid kernel sizes
        nt0 = nt_cnt;
        start_frame(4, 1, 1, 1, 0);
        repeat (5) @(negedge clk);
        chk("err_k4", err_ksize, 1);
        chk("busy_k4", busy, 0);
        start_frame(11, 1, 1, 1, 0);
        repeat (5) @(negedge clk);
        chk("err_k11", err_ksize, 1);
        chk("busy_k11", busy, 0);
        chk("no_trans", nt_cnt - nt0, 0);
        base = out_cnt;
        d0 = done_cnt;
        start_frame(3, 1, 1, 1, 77);
        chk("err_clear", err_ksize, 0);
        wait_done(base, d0, 1);

        // reset in the middle of a MAC
        start_frame(3, 9, 9, 0, 0);
        base = out_cnt;
        t = 0;
        while ((out_cnt - base < 3 || !new_sample_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", oif.out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pix", oif.out_pix, 0);
        chk("mid_rst_req", new_sample_req, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sbq.delete();
        run_frame(3, 9, 9, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
